tiro_nave: RTL
==============

# tiro_nave

Player-shot stage that sits directly downstream of the ship block. It consumes the ship's horizontal position and fire request, launches a single projectile from the ship's nose, and moves it upward on a fixed tick. It retires the projectile on an alien hit or at the top of the playfield, and renders it into the VGA pixel stream. Its bullet coordinates feed the alien/collision block, which returns `hit`.

## Interface

Parameters:
- SHIP_Y, 490: top row of the ship sprite.
- SHIP_W, 22: ship sprite width in pixels.
- BULLET_W, 2: projectile width in pixels.
- BULLET_H, 8: projectile height in pixels.
- STEP_PIX, 4: pixels moved upward per step tick.
- STEP_CYCLES, 500000: clk cycles per step tick.
- TOP_Y, 40: topmost legal projectile row.
- COOLDOWN_CYCLES, 25000000: dead time after a shot ends before the next launch.

Ports (reset: `reset`, synchronous, active-high; clock: `clk`):
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- fire  in  1  ship fire request, level; a launch occurs on its rising edge only.
- ship_x  in  11  ship sprite left column.
- hit  in  1  collision block reports that the projectile struck an alien.
- h_counter  in  10  current VGA column.
- v_counter  in  10  current VGA row.
- bullet_active  out  1  projectile in flight.
- bullet_x  out  11  projectile left column.
- bullet_y  out  10  projectile top row.
- shot_end  out  1  one-cycle pulse when a flight ends.
- shot_hit  out  1  one-cycle pulse, coincident with `shot_end`, when the end was caused by `hit`.
- R, G, B  out  8 each  projectile pixel colour; 0 elsewhere.

## Operation

- FSM has three states: IDLE, FLIGHT, COOLDOWN. Reset enters IDLE.
- `fire_q` registers `fire`. `fire_rise = fire & ~fire_q`.
- **IDLE:** on `fire_rise`:
  - latch `bullet_x = ship_x + (SHIP_W-BULLET_W)/2` (445 → 455);
  - set `bullet_y = SHIP_Y - BULLET_H` (482);
  - clear the step counter; go to FLIGHT.
- **FLIGHT:** the step counter runs 0..STEP_CYCLES-1 and asserts `step` at terminal count.
  - `hit` has priority over `step` in the same cycle: end the flight with `shot_hit`=1.
  - Else, on `step`, if `bullet_y < TOP_Y + STEP_PIX`, end the flight as a miss.
  - Else, on `step`, `bullet_y -= STEP_PIX`.
  - Ending a flight pulses `shot_end`, drops `bullet_active`, and goes to COOLDOWN.
- **COOLDOWN:** count COOLDOWN_CYCLES, then go to IDLE. `fire` is ignored, including edges seen during this state; a level still held on IDLE entry does not launch.
- `fire` rises are ignored during FLIGHT. `hit` is ignored outside FLIGHT.
- `bullet_x` stays frozen during flight; later ship motion does not affect it.
- Arithmetic is unsigned. `h_counter`/`v_counter` are zero-extended to 11 bits for comparisons. `bullet_y` never underflows because the end test precedes the subtraction.
- **Pixel:** when `bullet_active` and `bullet_x ≤ h < bullet_x+BULLET_W` and `bullet_y ≤ v < bullet_y+BULLET_H`, output R=FF, G=FF, B=00. Otherwise output all zero.

## Timing

- All outputs are registered.
- Reset values: `bullet_active`=0, `bullet_x`=0, `bullet_y`=0, `shot_end`=0, `shot_hit`=0, R=G=B=0, state IDLE, all counters 0.
- Launch: `bullet_active` goes high the cycle after the clk edge that samples `fire_rise`.
- First move occurs STEP_CYCLES cycles after launch.
- `hit` → `shot_end`/`shot_hit` high and `bullet_active` low on the next edge.
- RGB has 1-cycle latency from `h_counter`/`v_counter`.
- Reset asserted mid-flight or mid-cooldown returns to IDLE with reset values on the next edge. No `shot_end` is issued.

## Structure

- Shared package `jogo_pkg` holds SHIP_Y, SHIP_W, TOP_Y, playfield bounds, the colour constants (`COR_TIRO`=FFFF00), and the FSM state enum.
- The ship block imports the same SHIP_Y/SHIP_W so sprite and launch point cannot diverge.
- One sub-module, `tick_div`: a parameterised terminal-count divider with synchronous clear. It is instantiated for the step counter; the cooldown counter is inline.

## Test plan

Bench overrides: STEP_CYCLES=4, COOLDOWN_CYCLES=8.

1. Reset, then `ship_x`=445 and a `fire` pulse → next cycle `bullet_active`=1, `bullet_x`=455, `bullet_y`=482; after 4 cycles `bullet_y`=478.
2. Miss path: let the shot fly with no `hit` → `bullet_y` reaches 42 after 110 steps. On step 111, `shot_end`=1, `shot_hit`=0, `bullet_active`=0. Then 8 COOLDOWN cycles, then IDLE.
3. `hit` asserted on the same cycle as `step` while `bullet_y`=300 → `bullet_y` stays 300, `shot_end`=`shot_hit`=1 for one cycle, `bullet_active`=0.
4. `fire` held high through the whole flight and cooldown → no relaunch. Drop and re-raise `fire` in IDLE → a new launch at the current `ship_x`.
5. Pixel test with the bullet at (455,482): `h_counter`=455/456 and `v_counter`=482..489 → RGB=FF,FF,00 one cycle later. `h_counter`=457 or `v_counter`=490 → RGB=0.
6. Reset asserted mid-flight at `bullet_y`=200 → next cycle all outputs are 0, with no `shot_end` pulse. A following `fire` rise launches normally.

Source files
------------

// File: rtl/jogo_pkg.sv
// Game-wide constants shared by the ship, shot and alien blocks.
// Launch geometry lives here so the ship sprite and the shot origin cannot drift apart.
package jogo_pkg;

    localparam int SHIP_Y = 490;
    localparam int SHIP_W = 22;
    localparam int TOP_Y  = 40;

    localparam int PLAY_X_MIN = 0;
    localparam int PLAY_X_MAX = 799;
    localparam int PLAY_Y_MIN = 40;
    localparam int PLAY_Y_MAX = 599;

    localparam logic [23:0] COR_TIRO = 24'hFFFF00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } tiro_state_t;

endpackage

// File: rtl/tiro_nave_tick_div.sv
// Terminal-count divider: counts 0..CYCLES-1 while enabled and flags the last count.
// A synchronous clear restarts the period so the first tick lands CYCLES cycles later.
module tick_div #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/tiro_nave.sv
// Player shot: launches from the ship nose on a fire edge, climbs on a fixed tick,
// retires on hit or at the top row, then enforces a cooldown before the next launch.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no shot; a fire rising edge launches one
//   FLIGHT   | shot climbing; ends on hit (priority) or at the top row
//   COOLDOWN | dead time after a shot ends; fire is ignored
module tiro_nave
    import jogo_pkg::tiro_state_t, jogo_pkg::IDLE, jogo_pkg::FLIGHT,
           jogo_pkg::COOLDOWN, jogo_pkg::COR_TIRO;
#(
    parameter int SHIP_Y          = jogo_pkg::SHIP_Y,
    parameter int SHIP_W          = jogo_pkg::SHIP_W,
    parameter int BULLET_W        = 2,
    parameter int BULLET_H        = 8,
    parameter int STEP_PIX        = 4,
    parameter int STEP_CYCLES     = 500000,
    parameter int TOP_Y           = jogo_pkg::TOP_Y,
    parameter int COOLDOWN_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire,
    input  logic [10:0] ship_x,
    input  logic        hit,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    output logic        bullet_active,
    output logic [10:0] bullet_x,
    output logic [9:0]  bullet_y,
    output logic        shot_end,
    output logic        shot_hit,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
);

    localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    tiro_state_t   state;
    logic          fire_q;
    logic          fire_rise;
    logic          step;
    logic          launch;
    logic [CW-1:0] cool_cnt;

    assign fire_rise = fire & ~fire_q;
    assign launch    = (state == IDLE) && fire_rise;

    tick_div #(
        .CYCLES (STEP_CYCLES)
    ) u_step (
        .clk   (clk),
        .reset (reset),
        .en    (state == FLIGHT),
        .clr   (launch),
        .tc    (step)
    );

    // fire_q tracks fire in every state, so edges seen during flight or cooldown are consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            fire_q        <= 1'b0;
            bullet_active <= 1'b0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            shot_end      <= 1'b0;
            shot_hit      <= 1'b0;
            cool_cnt      <= '0;
        end else begin
            fire_q   <= fire;
            shot_end <= 1'b0;
            shot_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire_rise) begin
                        bullet_x      <= ship_x + 11'((SHIP_W - BULLET_W) / 2);
                        bullet_y      <= 10'(SHIP_Y - BULLET_H);
                        bullet_active <= 1'b1;
                        state         <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (hit || (step && ({1'b0, bullet_y} < 11'(TOP_Y + STEP_PIX)))) begin
                        shot_end      <= 1'b1;
                        shot_hit      <= hit;
                        bullet_active <= 1'b0;
                        cool_cnt      <= CW'(COOLDOWN_CYCLES - 1);
                        state         <= COOLDOWN;
                    end else if (step) begin
                        bullet_y <= bullet_y - 10'(STEP_PIX);
                    end
                end
                COOLDOWN: begin
                    if (cool_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [11:0] h_ext;
    logic [11:0] x_end;
    logic [10:0] v_ext;
    logic [10:0] y_end;
    logic        in_box;

    assign h_ext  = {2'b00, h_counter};
    assign x_end  = {1'b0, bullet_x} + 12'(BULLET_W);
    assign v_ext  = {1'b0, v_counter};
    assign y_end  = {1'b0, bullet_y} + 11'(BULLET_H);
    assign in_box = bullet_active
                    && (h_ext >= {1'b0, bullet_x}) && (h_ext < x_end)
                    && (v_ext >= {1'b0, bullet_y}) && (v_ext < y_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            {R, G, B} <= 24'h0;
        end else begin
            {R, G, B} <= in_box ? COR_TIRO : 24'h0;
        end
    end

endmodule
